// File: rtl/apb_slave_pkg.sv
// rtl/apb_slave_pkg.sv - shared types and constants for the APB register-bank completer
//
// Purpose : FSM state encoding, WAITCFG register index and wait-counter width.
// Ports   : none (package).

package apb_slave_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam int REG_WAITCFG = 0;
    localparam int WAIT_W      = 4;

endpackage

// File: rtl/apb_slv_regbank.sv
// rtl/apb_slv_regbank.sv - byte-strobed register array with registered read port
//
// Purpose : holds reg[0..DEPTH-1], applies strobed writes, and registers the
//           read response that drives PRDATA.
// Ports   : i_clk, i_resetn        clock, synchronous active-low reset
//           i_wr_en/idx/strb/data  strobed write port (commits at the clock edge)
//           i_rd_load              capture a new read response this edge
//           i_rd_en                1 = capture reg[i_rd_idx], 0 = capture zero
//           i_rd_idx               read index
//           i_rd_clr               force the read response to zero
//           o_rdata                registered read response
//           o_wait_cnt             WAITCFG wait-state count field

module apb_slv_regbank
    import apb_slave_pkg::*;
#(
    parameter int PDATA_SIZE  = 8,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 2,
    parameter int IDX_W       = 4
) (
    input  logic                    i_clk,
    input  logic                    i_resetn,
    input  logic                    i_wr_en,
    input  logic [IDX_W-1:0]        i_wr_idx,
    input  logic [PDATA_SIZE/8-1:0] i_wr_strb,
    input  logic [PDATA_SIZE-1:0]   i_wr_data,
    input  logic                    i_rd_load,
    input  logic                    i_rd_en,
    input  logic [IDX_W-1:0]        i_rd_idx,
    input  logic                    i_rd_clr,
    output logic [PDATA_SIZE-1:0]   o_rdata,
    output logic [WAIT_W-1:0]       o_wait_cnt
);

    localparam int STRB_W = PDATA_SIZE / 8;

    logic [PDATA_SIZE-1:0] r_regs [DEPTH];
    logic [PDATA_SIZE-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= (i == REG_WAITCFG) ? PDATA_SIZE'(WAIT_STATES) : '0;
            end
        end else if (i_wr_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (i_wr_strb[b]) begin
                    r_regs[i_wr_idx][b*8 +: 8] <= i_wr_data[b*8 +: 8];
                end
            end
        end
    end

    // Clear has priority so a completing/aborting transfer always returns
    // PRDATA to zero, even if a load were requested in the same cycle.
    always_ff @(posedge i_clk) begin
        if (!i_resetn || i_rd_clr) begin
            r_rdata <= '0;
        end else if (i_rd_load) begin
            r_rdata <= i_rd_en ? r_regs[i_rd_idx] : '0;
        end
    end

    assign o_rdata    = r_rdata;
    assign o_wait_cnt = r_regs[REG_WAITCFG][WAIT_W-1:0];

endmodule

// File: rtl/apb_regbank_slave.sv
// rtl/apb_regbank_slave.sv - APB4 completer with byte register bank, wait states and error response
//
// Purpose : accepts APB setup/access phases, inserts WAITCFG[3:0] wait states,
//           and responds from apb_slv_regbank. Out-of-range addresses error.
//           Optional macro APB_SLV_PROT_CHECK_EN: unprivileged (PPROT[0]=0)
//           accesses to WAITCFG also error.
// Ports   : PCLK, PRESETn                  clock, synchronous active-low reset
//           PSEL, PENABLE, PWRITE, PPROT   APB control
//           PSTRB, PADDR, PWDATA           write strobes, byte address, write data
//           PRDATA, PREADY, PSLVERR        registered response

module apb_regbank_slave
    import apb_slave_pkg::*;
#(
    parameter int PADDR_SIZE  = 10,
    parameter int PDATA_SIZE  = 8,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 2
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic [2:0]              PPROT,
    input  logic                    PWRITE,
    input  logic [PDATA_SIZE/8-1:0] PSTRB,
    input  logic [PADDR_SIZE-1:0]   PADDR,
    input  logic [PDATA_SIZE-1:0]   PWDATA,
    output logic [PDATA_SIZE-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int STRB_W = PDATA_SIZE / 8;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [WAIT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_write;
    logic                  r_err;
    logic [STRB_W-1:0]     r_strb;
    logic [PDATA_SIZE-1:0] r_wdata;
    logic                  r_ready;
    logic                  r_slverr;

    logic [IDX_W-1:0]      w_idx;
    logic                  w_range_err;
    logic                  w_prot_err;
    logic                  w_err;
    logic                  w_unused;
    logic [WAIT_W-1:0]     w_wait;

    logic                  w_setup;
    logic                  w_abort;
    logic                  w_complete;
    logic                  w_waiting;
    logic                  w_rsp_load;
    logic                  w_rsp_err;
    logic                  w_rsp_write;
    logic [IDX_W-1:0]      w_rsp_idx;

    logic [WAIT_W-1:0]     w_cnt_nxt;
    logic                  w_ready_nxt;
    logic                  w_slverr_nxt;
    logic                  w_rd_load;
    logic                  w_rd_clr;
    logic                  w_rd_en;
    logic                  w_wr_en;

    // Live address decode, used at the setup edge.
    assign w_idx       = PADDR[IDX_W-1:0];
    assign w_range_err = ({1'b0, PADDR} >= (PADDR_SIZE+1)'(DEPTH));

`ifdef APB_SLV_PROT_CHECK_EN
    assign w_prot_err = !w_range_err && (w_idx == IDX_W'(REG_WAITCFG)) && !PPROT[0];
    assign w_unused   = ^PPROT[2:1];
`else
    assign w_prot_err = 1'b0;
    assign w_unused   = ^PPROT;
`endif

    assign w_err = w_range_err | w_prot_err;

    assign w_setup    = (r_state == IDLE) && PSEL && !PENABLE;
    assign w_abort    = (r_state == ACCESS) && !PSEL;
    assign w_complete = (r_state == ACCESS) && PSEL && PENABLE && r_ready;
    assign w_waiting  = (r_state == ACCESS) && PSEL && PENABLE && !r_ready;

    // Response is produced either at the setup edge (zero wait states) or at
    // the edge where the counter runs out; the first case must use the live
    // bus fields because nothing has been latched yet.
    assign w_rsp_load  = (w_setup && (w_wait == '0)) || (w_waiting && (r_cnt <= WAIT_W'(1)));
    assign w_rsp_err   = (r_state == IDLE) ? w_err  : r_err;
    assign w_rsp_write = (r_state == IDLE) ? PWRITE : r_write;
    assign w_rsp_idx   = (r_state == IDLE) ? w_idx  : r_idx;

    // State register and latched transfer fields.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_ready  <= 1'b0;
            r_slverr <= 1'b0;
            r_idx    <= '0;
            r_write  <= 1'b0;
            r_err    <= 1'b0;
            r_strb   <= '0;
            r_wdata  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ready  <= w_ready_nxt;
            r_slverr <= w_slverr_nxt;
            if (w_setup) begin
                r_idx   <= w_idx;
                r_write <= PWRITE;
                r_err   <= w_err;
                r_strb  <= PSTRB;
                r_wdata <= PWDATA;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_setup) w_state_nxt = ACCESS;
            ACCESS:  if (w_abort || w_complete) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Counter, response and write-port control.
    always_comb begin
        w_cnt_nxt    = r_cnt;
        w_ready_nxt  = r_ready;
        w_slverr_nxt = r_slverr;
        w_rd_load    = 1'b0;
        w_rd_clr     = 1'b0;
        w_wr_en      = 1'b0;
        w_rd_en      = !w_rsp_write && !w_rsp_err;

        if (w_setup) begin
            w_cnt_nxt = w_wait;
        end else if (w_abort || w_complete) begin
            w_cnt_nxt    = '0;
            w_ready_nxt  = 1'b0;
            w_slverr_nxt = 1'b0;
            w_rd_clr     = 1'b1;
            w_wr_en      = w_complete && r_write && !r_err;
        end else if (w_waiting) begin
            w_cnt_nxt = (r_cnt > WAIT_W'(1)) ? r_cnt - WAIT_W'(1) : '0;
        end

        if (w_rsp_load) begin
            w_ready_nxt  = 1'b1;
            w_slverr_nxt = w_rsp_err;
            w_rd_load    = 1'b1;
        end
    end

    apb_slv_regbank #(
        .PDATA_SIZE  (PDATA_SIZE),
        .DEPTH       (DEPTH),
        .WAIT_STATES (WAIT_STATES),
        .IDX_W       (IDX_W)
    ) u_regbank (
        .i_clk      (PCLK),
        .i_resetn   (PRESETn),
        .i_wr_en    (w_wr_en),
        .i_wr_idx   (r_idx),
        .i_wr_strb  (r_strb),
        .i_wr_data  (r_wdata),
        .i_rd_load  (w_rd_load),
        .i_rd_en    (w_rd_en),
        .i_rd_idx   (w_rsp_idx),
        .i_rd_clr   (w_rd_clr),
        .o_rdata    (PRDATA),
        .o_wait_cnt (w_wait)
    );

    assign PREADY  = r_ready;
    assign PSLVERR = r_slverr;

endmodule

// File: tb/tb_apb_regbank_slave.sv
// tb/tb_apb_regbank_slave.sv - directed self-checking bench for apb_regbank_slave

module tb_apb_regbank_slave;

    logic       PCLK;
    logic       PRESETn;
    logic       PSEL;
    logic       PENABLE;
    logic [2:0] PPROT;
    logic       PWRITE;
    logic [0:0] PSTRB;
    logic [9:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic       PSLVERR;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_regs [16];

    apb_regbank_slave #(
        .PADDR_SIZE  (10),
        .PDATA_SIZE  (8),
        .DEPTH       (16),
        .WAIT_STATES (2)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PPROT   (PPROT),
        .PWRITE  (PWRITE),
        .PSTRB   (PSTRB),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; drives setup immediately and returns
    // just after the completion edge, so calls chain back-to-back.
    task automatic apb_xfer(input logic wr, input logic [9:0] addr, input logic [7:0] wd,
                            input logic strb, input logic [2:0] prot,
                            output logic [7:0] rd, output logic err, output int ncyc);
        int   n;
        logic bad;
        logic done;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr;
        PWDATA = wd; PSTRB = strb; PPROT = prot;
        bad = 1'b0; done = 1'b0; rd = '0; err = 1'b0; n = 0;
        @(negedge PCLK);
        if (PREADY || PSLVERR || PRDATA != 8'h00) bad = 1'b1;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        while (!done && n < 40) begin
            @(negedge PCLK);
            n++;
            if (PREADY) begin
                rd   = PRDATA;
                err  = PSLVERR;
                done = 1'b1;
            end else if (PSLVERR || PRDATA != 8'h00) begin
                bad = 1'b1;
            end
            @(posedge PCLK); #1;
        end
        ncyc = done ? n : -1;
        PSEL = 1'b0; PENABLE = 1'b0;
        check_eq("quiet_before_ready", {31'd0, bad}, 32'd0);
    endtask

    task automatic xfer_chk(input string tag, input logic wr, input logic [9:0] addr,
                            input logic [7:0] wd, input logic strb, input logic [2:0] prot,
                            input logic [7:0] exp_rd, input logic exp_err, input int exp_cyc);
        logic [7:0] rd;
        logic       err;
        int         ncyc;
        apb_xfer(wr, addr, wd, strb, prot, rd, err, ncyc);
        check_eq({tag, "_prdata"}, {24'd0, rd}, {24'd0, exp_rd});
        check_eq({tag, "_pslverr"}, {31'd0, err}, {31'd0, exp_err});
        check_eq({tag, "_cycles"}, ncyc, exp_cyc);
    endtask

    initial begin
        logic seen_ready;

        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PPROT = 3'b001;
        PWRITE = 1'b0; PSTRB = 1'b0; PADDR = '0; PWDATA = '0;
        for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;

        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        check_eq("rst_pready", {31'd0, PREADY}, 32'd0);
        check_eq("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
        check_eq("rst_prdata", {24'd0, PRDATA}, 32'd0);
        @(posedge PCLK); #1;
        PRESETn = 1'b1;

        // W=2 from reset: 3 access cycles
        xfer_chk("rd_waitcfg_rst", 0, 10'h000, 8'h00, 0, 3'b001, 8'h02, 0, 3);
        xfer_chk("wr5_a5",         1, 10'h005, 8'hA5, 1, 3'b001, 8'h00, 0, 3);
        xfer_chk("rd5_a5",         0, 10'h005, 8'h00, 0, 3'b001, 8'hA5, 0, 3);
        xfer_chk("wr5_nostrb",     1, 10'h005, 8'h3C, 0, 3'b001, 8'h00, 0, 3);
        xfer_chk("rd5_kept",       0, 10'h005, 8'h00, 1, 3'b001, 8'hA5, 0, 3);
        exp_regs[5] = 8'hA5;

        // W=0: single access cycle, back-to-back
        xfer_chk("wr_wait0",       1, 10'h000, 8'h00, 1, 3'b001, 8'h00, 0, 3);
        xfer_chk("rd5_w0",         0, 10'h005, 8'h00, 0, 3'b001, 8'hA5, 0, 1);
        xfer_chk("rd0_w0_b2b",     0, 10'h000, 8'h00, 0, 3'b001, 8'h00, 0, 1);
        exp_regs[0] = 8'h00;

        // out-of-range
        xfer_chk("rd_oor_10",      0, 10'h010, 8'h00, 0, 3'b001, 8'h00, 1, 1);
        xfer_chk("wr_oor_10",      1, 10'h010, 8'hFF, 1, 3'b001, 8'h00, 1, 1);
        xfer_chk("rd_oor_3ff",     0, 10'h3FF, 8'h00, 0, 3'b001, 8'h00, 1, 1);
        xfer_chk("wr15_5a",        1, 10'h00F, 8'h5A, 1, 3'b001, 8'h00, 0, 1);
        exp_regs[15] = 8'h5A;
        for (int i = 0; i < 16; i++) begin
            xfer_chk($sformatf("rdall_%0d", i), 0, 10'(i), 8'h00, 0, 3'b001, exp_regs[i], 0, 1);
        end

        // W=3: write takes effect from the next setup
        xfer_chk("wr_wait3",       1, 10'h000, 8'h03, 1, 3'b001, 8'h00, 0, 1);
        xfer_chk("rd0_w3",         0, 10'h000, 8'h00, 0, 3'b001, 8'h03, 0, 4);

        // abort: drop PSEL after two waiting access cycles
        seen_ready = 1'b0;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 10'h003;
        PWDATA = 8'h77; PSTRB = 1'b1; PPROT = 3'b001;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        repeat (2) begin
            @(negedge PCLK);
            if (PREADY) seen_ready = 1'b1;
            @(posedge PCLK); #1;
        end
        PSEL = 1'b0; PENABLE = 1'b0;
        repeat (4) begin
            @(negedge PCLK);
            if (PREADY || PSLVERR || PRDATA != 8'h00) seen_ready = 1'b1;
        end
        check_eq("abort_no_ready", {31'd0, seen_ready}, 32'd0);
        @(posedge PCLK); #1;
        xfer_chk("rd3_after_abort", 0, 10'h003, 8'h00, 0, 3'b001, 8'h00, 0, 4);

        // reset in the middle of a write
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 10'h005;
        PWDATA = 8'h99; PSTRB = 1'b1; PPROT = 3'b001;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        @(posedge PCLK); #1;
        PRESETn = 1'b0;
        @(posedge PCLK);
        @(negedge PCLK);
        check_eq("midrst_pready", {31'd0, PREADY}, 32'd0);
        check_eq("midrst_pslverr", {31'd0, PSLVERR}, 32'd0);
        check_eq("midrst_prdata", {24'd0, PRDATA}, 32'd0);
        PSEL = 1'b0; PENABLE = 1'b0; PRESETn = 1'b1;
        @(posedge PCLK); #1;
        xfer_chk("rd0_after_rst",  0, 10'h000, 8'h00, 0, 3'b001, 8'h02, 0, 3);
        xfer_chk("rd5_after_rst",  0, 10'h005, 8'h00, 0, 3'b001, 8'h00, 0, 3);

`ifdef APB_SLV_PROT_CHECK_EN
        xfer_chk("wr0_unpriv",     1, 10'h000, 8'h07, 1, 3'b000, 8'h00, 1, 3);
        xfer_chk("rd0_unpriv",     0, 10'h000, 8'h00, 0, 3'b000, 8'h00, 1, 3);
        xfer_chk("rd0_kept",       0, 10'h000, 8'h00, 0, 3'b001, 8'h02, 0, 3);
        xfer_chk("wr0_priv",       1, 10'h000, 8'h07, 1, 3'b001, 8'h00, 0, 3);
        xfer_chk("rd0_priv",       0, 10'h000, 8'h00, 0, 3'b001, 8'h07, 0, 8);
`else
        xfer_chk("wr0_noprot",     1, 10'h000, 8'h07, 1, 3'b000, 8'h00, 0, 3);
        xfer_chk("rd0_noprot",     0, 10'h000, 8'h00, 0, 3'b000, 8'h07, 0, 8);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
